seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Recovers digit values from a 7-segment drive bus.
- Monitors the active-low segment pattern and the one-hot digit strobe of a multiplexed or static HEX display driver.
- Captures a pattern once it has been stable, then decodes it back to a numeric value. This is the inverse of the team's 5-bit-value-to-LED encoder.
- Used for display loop-back self-test and for reading external 7-seg driver chips into the design.

Parameters:
- NUM_DIGITS, 6, number of display digits (DE1-SoC HEX0..HEX5).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture is accepted; legal range 2..255.
- IDX_W, $clog2(NUM_DIGITS), derived localparam, width of the digit index.

Ports:
- clk, input, 1, system clock; all inputs synchronous to it.
- reset_n, input, 1, asynchronous active-low reset.
- leds, input, 7, segment pattern (bit6..bit0 = segments 6..0), active-low.
- digit_sel, input, NUM_DIGITS, one-hot active-high strobe naming the digit that leds belongs to.
- ev_valid, output, 1, capture event available.
- ev_ready, input, 1, consumer accepts the event.
- ev_digit, output, IDX_W, index of the captured digit.
- ev_value, output, 5, decoded value 0..9, zero-extended to 5 bits.
- ev_blank, output, 1, pattern was all-off (7'b1111111).
- ev_bad, output, 1, pattern not in the decode table.
- values, output, NUM_DIGITS*5, last good value per digit; digit i occupies bits [5i+4:5i].
- blank_mask, output, NUM_DIGITS, bit i set when digit i last captured blank.
- overflow, output, 1, sticky; an event was dropped.

Behaviour:
- Reset (async, reset_n=0):
  - state=S_IDLE, cand/cnt cleared.
  - ev_valid=0, ev_digit=0, ev_value=0, ev_blank=0, ev_bad=0.
  - values=0, blank_mask=all ones, overflow=0.
- Sample valid when digit_sel is exactly one-hot. Zero or multiple bits set counts as invalid.
- FSM states: S_IDLE, S_SETTLE, S_LOCKED.
- S_IDLE:
  - Valid sample: latch {leds, digit_sel} into cand, cnt=1, go to S_SETTLE.
  - Otherwise stay in S_IDLE.
- S_SETTLE:
  - Sample equals cand: cnt++. On the edge where cnt reaches STABLE_CYCLES, accept and go to S_LOCKED.
  - Sample differs and is valid: relatch cand, cnt=1, stay in S_SETTLE.
  - Sample differs and is invalid: go to S_IDLE.
- S_LOCKED:
  - Stay while sample equals cand; there is no re-capture of a held pattern.
  - Any change is handled exactly as in S_IDLE: valid goes to S_SETTLE with cnt=1, invalid goes to S_IDLE.
- Latency: a pattern sampled identically on STABLE_CYCLES consecutive edges gives ev_valid=1 in the cycle after the last of those edges.
- Decode, combinational on cand:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F→blank (value 0, ev_bad=0).
  - Anything else→bad (value 0).
- Accept updates:
  - Good digit: values[d]=value, blank_mask[d]=0.
  - Blank: blank_mask[d]=1, values[d] unchanged.
  - Bad: values and blank_mask unchanged.
- Event handshake:
  - ev_valid rises on accept and is held with its payload stable until a cycle with ev_valid && ev_ready. It clears on that edge unless a new accept coincides.
  - Accept while ev_valid=1 and ev_ready=1: the new event replaces the old one and ev_valid stays 1.
  - Accept while ev_valid=1 and ev_ready=0: the new event is dropped and overflow is set. values and blank_mask still update.
  - overflow clears only on reset.
- ev_ready is ignored while ev_valid=0.
- Reset mid-settle or mid-event: the pending capture and event are discarded; nothing is emitted after release until a full new settle completes.
- cnt saturates and needs no more than 8 bits.

Decomposition:
- seg7_pkg holds:
  - The SEG_0..SEG_9 and SEG_BLANK 7-bit pattern constants, shared with the encoder so both directions use one table.
  - The state_t enum {S_IDLE, S_SETTLE, S_LOCKED}.
- One sub-module, seg7_inv: combinational pattern→{value[4:0], is_blank, is_bad}.
- seg7_capture holds the FSM, counter, event register and value store.

Test Plan:
- Reset release, then leds=0x24, digit_sel=6'b000100 held 4 cycles:
  - ev_valid rises the cycle after the 4th edge with ev_digit=2, ev_value=2.
  - values[14:10]=2, blank_mask[2]=0.
- Pattern 0x30 on digit 0 for 3 cycles, then 0x19 for 4 cycles, ev_ready=1:
  - Exactly one event: digit 0, value 4; no event for 3.
- Loop-back: drive all 10 encoder outputs for values 0..9 on digit 5, each held 6 cycles:
  - 10 events in order, values 0..9, ev_bad=0.
  - Held patterns produce no duplicates.
- leds=0x7F on digit 1:
  - ev_blank=1, blank_mask[1]=1, values[9:5] unchanged.
- leds=0x55:
  - ev_bad=1, values and blank_mask unchanged.
- digit_sel=6'b000011 or 0:
  - No event, FSM in S_IDLE.
- ev_ready=0 with two successive captures:
  - First payload stays stable, the second is dropped, overflow=1.
- Assert reset_n=0 at cnt=3 of a settle:
  - All outputs return to their reset values immediately.
  - No event after release until a new 4-cycle stable sample completes.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern table and capture FSM state type.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TAB [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                          SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LOCKED} state_t;
  function automatic logic [6:0] seg_encode(input logic [4:0] v);
    return (v < 5'd10) ? SEG_TAB[v[3:0]] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/seg7_inv.sv
// seg7_inv: active-low segment pattern back to a digit value, flagging blank and unknown patterns.
module seg7_inv
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [4:0] value,
  output logic       is_blank,
  output logic       is_bad
);
  logic hit;
  always_comb begin
    value = '0;
    hit = 1'b0;
    for (int i = 0; i < 10; i++)
      if (pat == SEG_TAB[i]) begin
        value = 5'(i);
        hit = 1'b1;
      end
    is_blank = (pat == SEG_BLANK);
    is_bad = !hit && !is_blank;
  end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: debounces a multiplexed 7-seg drive bus, decodes stable patterns
// and reports them as handshaked events plus a per-digit value store.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int STABLE_CYCLES = 4,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              leds,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [IDX_W-1:0]        ev_digit,
  output logic [4:0]              ev_value,
  output logic                    ev_blank,
  output logic                    ev_bad,
  output logic [NUM_DIGITS*5-1:0] values,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    overflow
);
  localparam int CW = 7 + NUM_DIGITS;
  state_t state_q, state_d;
  logic [CW-1:0] cand_q, cand_d, samp;
  logic [7:0] cnt_q, cnt_d;
  logic ev_valid_q, ev_valid_d, ev_blank_q, ev_blank_d, ev_bad_q, ev_bad_d;
  logic [IDX_W-1:0] ev_digit_q, ev_digit_d, dig_idx;
  logic [4:0] ev_value_q, ev_value_d, dec_value;
  logic [NUM_DIGITS*5-1:0] values_q, values_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic overflow_q, overflow_d, vld, same, accept, load, dec_blank, dec_bad;

  seg7_inv u_inv (.pat(cand_q[CW-1:NUM_DIGITS]), .value(dec_value), .is_blank(dec_blank), .is_bad(dec_bad));

  assign samp = {leds, digit_sel};
  assign vld = (digit_sel != '0) && ((digit_sel & (digit_sel - 1'b1)) == '0);
  assign same = (samp == cand_q) && (state_q != S_IDLE);

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (cand_q[i]) dig_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    accept = 1'b0;
    if (same) begin
      if (state_q == S_SETTLE) begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        accept = (cnt_q == 8'(STABLE_CYCLES - 1));
        state_d = accept ? S_LOCKED : S_SETTLE;
      end
    end else if (vld) begin
      cand_d = samp;
      cnt_d = 8'd1;
      state_d = S_SETTLE;
    end else begin
      state_d = S_IDLE;
    end
  end

  // A capture that finds the event slot full and unconsumed is dropped, but still updates the store.
  always_comb begin
    load = accept && (!ev_valid_q || ev_ready);
    ev_valid_d = load || (ev_valid_q && !ev_ready);
    ev_digit_d = load ? dig_idx : ev_digit_q;
    ev_value_d = load ? dec_value : ev_value_q;
    ev_blank_d = load ? dec_blank : ev_blank_q;
    ev_bad_d = load ? dec_bad : ev_bad_q;
    overflow_d = overflow_q || (accept && ev_valid_q && !ev_ready);
    values_d = values_q;
    blank_d = blank_q;
    if (accept && !dec_bad) begin
      blank_d[dig_idx] = dec_blank;
      if (!dec_blank) values_d[5*dig_idx +: 5] = dec_value;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      cand_q <= '0;
      cnt_q <= '0;
      ev_valid_q <= 1'b0;
      ev_digit_q <= '0;
      ev_value_q <= '0;
      ev_blank_q <= 1'b0;
      ev_bad_q <= 1'b0;
      values_q <= '0;
      blank_q <= '1;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      ev_valid_q <= ev_valid_d;
      ev_digit_q <= ev_digit_d;
      ev_value_q <= ev_value_d;
      ev_blank_q <= ev_blank_d;
      ev_bad_q <= ev_bad_d;
      values_q <= values_d;
      blank_q <= blank_d;
      overflow_q <= overflow_d;
    end

  assign ev_valid = ev_valid_q;
  assign ev_digit = ev_digit_q;
  assign ev_value = ev_value_q;
  assign ev_blank = ev_blank_q;
  assign ev_bad = ev_bad_q;
  assign values = values_q;
  assign blank_mask = blank_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed checks of capture latency, debounce, decode, store and event handshake.
module tb_seg7_capture;
  import seg7_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, ev_ready = 1'b0;
  logic [6:0] leds = '0;
  logic [5:0] digit_sel = '0;
  logic ev_valid, ev_blank, ev_bad, overflow;
  logic [2:0] ev_digit;
  logic [4:0] ev_value;
  logic [29:0] values, exp_vals;
  logic [5:0] blank_mask;
  logic [9:0] mon_q [$];
  int nvec = 0, nerr = 0;

  seg7_capture dut (
    .clk(clk), .reset_n(reset_n), .leds(leds), .digit_sel(digit_sel),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_digit(ev_digit), .ev_value(ev_value),
    .ev_blank(ev_blank), .ev_bad(ev_bad), .values(values), .blank_mask(blank_mask),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ev_valid && ev_ready) mon_q.push_back({ev_bad, ev_blank, ev_digit, ev_value});

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] l, input logic [5:0] s);
    leds = l;
    digit_sel = s;
  endtask

  initial begin
    step(2);
    chk("reset ev", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad}, 11'd0);
    chk("reset store", {values, blank_mask, overflow}, {30'd0, 6'h3F, 1'b0});
    reset_n = 1'b1;
    exp_vals = '0;
    // first capture: digit 2 shows "2"
    drive(7'h24, 6'b000100);
    step(3);
    chk("t1 early", ev_valid, 1'b0);
    step(1);
    exp_vals[14:10] = 5'd2;
    chk("t1 ev", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad}, {1'b1, 3'd2, 5'd2, 2'b00});
    chk("t1 store", {values, blank_mask}, {exp_vals, 6'h3B});
    ev_ready = 1'b1;
    step(4);
    chk("t1 no dup", ev_valid, 1'b0);
    // short-lived 3 must not capture; following 4 does
    mon_q.delete();
    drive(SEG_3, 6'b000001);
    step(3);
    drive(SEG_4, 6'b000001);
    step(5);
    exp_vals[4:0] = 5'd4;
    chk("t2 count", mon_q.size(), 1);
    if (mon_q.size() > 0) chk("t2 ev", mon_q[0], {2'b00, 3'd0, 5'd4});
    // loop-back of all ten encoder patterns on digit 5
    mon_q.delete();
    for (int v = 0; v < 10; v++) begin
      drive(seg_encode(5'(v)), 6'b100000);
      step(6);
    end
    exp_vals[29:25] = 5'd9;
    chk("t3 count", mon_q.size(), 10);
    for (int v = 0; v < 10 && v < mon_q.size(); v++)
      chk($sformatf("t3 ev%0d", v), mon_q[v], {2'b00, 3'd5, 5'(v)});
    chk("t3 store", {values, blank_mask}, {exp_vals, 6'h1A});
    // digit 1 shows "1", then goes blank
    drive(SEG_1, 6'b000010);
    step(6);
    exp_vals[9:5] = 5'd1;
    chk("t4 good", {values, blank_mask}, {exp_vals, 6'h18});
    ev_ready = 1'b0;
    drive(SEG_BLANK, 6'b000010);
    step(4);
    chk("t4 ev", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad}, {1'b1, 3'd1, 5'd0, 2'b10});
    chk("t4 store", {values, blank_mask}, {exp_vals, 6'h1A});
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    // unknown pattern on digit 3
    drive(7'h55, 6'b001000);
    step(4);
    chk("t5 ev", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad}, {1'b1, 3'd3, 5'd0, 2'b01});
    chk("t5 store", {values, blank_mask}, {exp_vals, 6'h1A});
    ev_ready = 1'b1;
    step(1);
    chk("t5 consumed", ev_valid, 1'b0);
    ev_ready = 1'b0;
    // invalid strobes
    drive(SEG_2, 6'b000011);
    step(6);
    chk("t6 multi ev", ev_valid, 1'b0);
    chk("t6 multi st", dut.state_q, S_IDLE);
    drive(SEG_2, 6'b000000);
    step(6);
    chk("t6 zero ev", ev_valid, 1'b0);
    chk("t6 zero st", dut.state_q, S_IDLE);
    chk("t6 store", {values, blank_mask}, {exp_vals, 6'h1A});
    // back-pressure: second capture dropped
    drive(SEG_5, 6'b010000);
    step(4);
    chk("t7 first", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad, overflow}, {1'b1, 3'd4, 5'd5, 3'b000});
    drive(SEG_6, 6'b001000);
    step(4);
    exp_vals[24:20] = 5'd5;
    exp_vals[19:15] = 5'd6;
    chk("t7 held", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad, overflow}, {1'b1, 3'd4, 5'd5, 3'b001});
    chk("t7 store", {values, blank_mask}, {exp_vals, 6'h02});
    // reset at cnt=3 with an event pending
    drive(SEG_7, 6'b000001);
    step(3);
    reset_n = 1'b0;
    #1;
    chk("t8 rst ev", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad}, 11'd0);
    chk("t8 rst store", {values, blank_mask, overflow}, {30'd0, 6'h3F, 1'b0});
    step(1);
    reset_n = 1'b1;
    step(3);
    chk("t8 no early", ev_valid, 1'b0);
    step(1);
    chk("t8 ev", {ev_valid, ev_digit, ev_value, ev_blank, ev_bad}, {1'b1, 3'd0, 5'd7, 2'b00});
    chk("t8 store", {values, blank_mask}, {30'd7, 6'h3E});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
